// File: rtl/alu_arb_pkg.sv
// Shared types and defaults for the ALU arbiter slice.
// Used by alu_arbiter (optional overflow output via ALU_ARB_OVF_EN) and rr_arbiter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int unsigned DEF_BUS_WIDTH = 32;
  localparam int unsigned DEF_NUM_REQ   = 2;

  // Requester index width, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  int unsigned          idx;

  // Rotate so that bit 0 is the requester at the pointer.
  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> ptr);

  always_comb begin
    any_grant = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      if (!any_grant && req_rot[off]) begin
        any_grant = 1'b1;
        idx       = 32'(ptr) + off;
      end
    end
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    grant_idx = ID_W'(idx);
    grant     = any_grant ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered add/sub ALU among NUM_REQ requesters, one op in flight.
// Define ALU_ARB_OVF_EN to add the registered signed-overflow output rsp_ovf.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
  parameter int unsigned ID_W      = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]           req_sub,
  output logic [BUS_WIDTH-1:0]         alu_a,
  output logic [BUS_WIDTH-1:0]         alu_b,
  output logic                         alu_sub,
  input  logic [BUS_WIDTH-1:0]         alu_c,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [BUS_WIDTH-1:0]         rsp_result,
  output logic                         rsp_zero
`ifdef ALU_ARB_OVF_EN
  ,
  output logic                         rsp_ovf
`endif
);

  localparam int unsigned MSB = BUS_WIDTH - 1;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    pend_id;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_grant;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_grant) state_nxt = EXEC;
      EXEC:    state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept is only offered while idle; the grant is already valid-qualified.
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state == IDLE) begin
      req_ready = grant;
      accept    = any_grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      pend_id    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sub    <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a   <= req_a[32'(grant_idx)*BUS_WIDTH +: BUS_WIDTH];
        alu_b   <= req_b[32'(grant_idx)*BUS_WIDTH +: BUS_WIDTH];
        alu_sub <= req_sub[grant_idx];
        pend_id <= grant_idx;
        ptr     <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);
      end
      if (state == CAPT) begin
        rsp_result <= alu_c;
        rsp_zero   <= (alu_c == '0);
        rsp_id     <= pend_id;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid  <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_OVF_EN
  // Signed overflow from the operands still held on the ALU inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_ovf <= 1'b0;
    end else if (state == CAPT) begin
      if (alu_sub) rsp_ovf <= (alu_a[MSB] != alu_b[MSB]) && (alu_c[MSB] != alu_a[MSB]);
      else         rsp_ovf <= (alu_a[MSB] == alu_b[MSB]) && (alu_c[MSB] != alu_a[MSB]);
    end
  end
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered add/sub ALU (one-cycle latency, clocked on clk) between NUM_REQ requesters.
- Each requester has a valid/ready request channel. One response channel returns result, zero flag and requester ID.
- One operation is in flight at a time. Sits between the decode/execute stages and the ALU instance.

Parameters:
- BUS_WIDTH, 32, operand/result width; must match the ALU's BUS_WIDTH.
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ) (min 1), width of rsp_id.

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- req_a  in  NUM_REQ*BUS_WIDTH  operand A; requester i at slice [i*BUS_WIDTH +: BUS_WIDTH].
- req_b  in  NUM_REQ*BUS_WIDTH  operand B; same packing.
- req_sub  in  NUM_REQ  1 = A-B, 0 = A+B.
- alu_a  out  BUS_WIDTH  registered operand A to the ALU.
- alu_b  out  BUS_WIDTH  registered operand B to the ALU.
- alu_sub  out  1  registered sub select to the ALU.
- alu_c  in  BUS_WIDTH  ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester served.
- rsp_result  out  BUS_WIDTH  captured result.
- rsp_zero  out  1  1 when rsp_result == 0.

Behaviour:
- Reset values (async on rst high): state IDLE, RR pointer 0, alu_a/alu_b/alu_sub 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0.
- FSM states: IDLE -> EXEC -> CAPT -> RESP -> IDLE.
- IDLE:
  - grant = first asserted req_valid at or after RR pointer, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 only for that grant; all req_ready are 0 in every other state.
  - On valid&ready at the edge: latch req_a/req_b/req_sub[g] into alu_a/alu_b/alu_sub; latch g as pending ID; pointer <= (g+1) mod NUM_REQ; go EXEC.
  - No valid: stay IDLE; pointer unchanged.
- EXEC: one cycle. The ALU samples operands at the end of this cycle. Go CAPT.
- CAPT: alu_c is valid during this cycle. At the edge: rsp_result <= alu_c, rsp_zero <= (alu_c == 0), rsp_id <= pending ID, rsp_valid <= 1. Go RESP.
- RESP:
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On rsp_ready at the edge: rsp_valid <= 0, go IDLE.
  - rsp_result, rsp_id and rsp_zero keep their last values after the handshake.
- The ALU's own zero flag is not consumed; it lags C by one cycle. rsp_zero is computed locally from alu_c.
- Timing:
  - Latency: accept edge to rsp_valid high = 2 cycles.
  - Minimum issue interval: 4 cycles with rsp_ready tied high.
- Arithmetic: modulo 2^BUS_WIDTH. Subtract wrap, e.g. 0 - 1 = all ones.
- Requesters must hold valid and operands stable until accepted. Deasserting valid before acceptance is legal; the request is simply not served.
- Simultaneous requests: RR order guarantees no starvation. A requester waits at most NUM_REQ-1 grants.
- Reset mid-operation: the in-flight op is dropped, no response is produced, and any later alu_c change is ignored.
- The alu_* outputs hold their last operands outside EXEC. This is harmless because the result is only captured in CAPT.

Optional Feature:
- Macro: ALU_ARB_OVF_EN.
- Defined: adds output rsp_ovf (1 bit, reset 0), registered in CAPT.
  - Add: ovf = (a[msb] == b[msb]) && (c[msb] != a[msb]).
  - Sub: ovf = (a[msb] != b[msb]) && (c[msb] != a[msb]).
  - Uses the latched alu_a/alu_b/alu_sub.
- Undefined: port absent; no extra logic.

Decomposition:
- Package alu_arb_pkg:
  - state enum {IDLE, EXEC, CAPT, RESP}.
  - Default BUS_WIDTH and NUM_REQ constants.
  - ID width helper function.
- Sub-module rr_arbiter (NUM_REQ parameter):
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; the pointer register lives in alu_arbiter.

Test Plan:
- Single add: req 0 valid, A=5, B=7, sub=0, rsp_ready=1 -> req_ready[0] in the first cycle; rsp_valid 2 cycles after accept with rsp_result=12, rsp_id=0, rsp_zero=0.
- Zero/wrap subtract: A=3, B=3, sub=1 -> result 0, rsp_zero=1. Then A=0, B=1, sub=1 -> result 0xFFFFFFFF, rsp_zero=0.
- Round robin: both requesters valid continuously with distinct ops, NUM_REQ=2 -> grant order 0,1,0,1; rsp_id alternates; issue spacing 4 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, no req_ready asserted; rsp_ready=1 -> return to IDLE next cycle.
- Reset mid-op: assert rst in CAPT -> rsp_valid stays 0, state IDLE, pointer 0; the next request is served normally.
- Overflow (ALU_ARB_OVF_EN): A=0x7FFFFFFF, B=1, add -> rsp_ovf=1. A=0x80000000, B=1, sub -> rsp_ovf=1. A=2, B=1, sub -> rsp_ovf=0.
